hls_ctrl_sequencer: RTL and testbench

- Initiator for the ap_ctrl_hs block-level handshake used by our HLS accelerators (sobel_0_obf and siblings).
- Accepts a command for N frames and issues ap_start per frame. Tracks ap_ready/ap_done, counts completed runs and measures per-run latency.
- A watchdog timeout and an abort path cover hung or cancelled runs.
- Sits between the host command/status logic and one accelerator's control ports.

---
 rtl/hls_ctrl_sequencer.sv | 161 ++++++++++++++++
 tb/tb_hls_ctrl_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_ctrl_sequencer.sv
// Initiator side of the ap_ctrl_hs handshake: runs an accelerator for N frames,
// counts completions, measures per-run latency and guards against hung runs.
module hls_ctrl_sequencer #(
    parameter int CNT_W          = 16,
    parameter int CYC_W          = 32,
    parameter int TIMEOUT_CYCLES = 16777215
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_frames,
    input  logic             abort,
    output logic             acc_ap_start,
    input  logic             acc_ap_ready,
    input  logic             acc_ap_done,
    input  logic             acc_ap_idle,
    output logic             busy,
    output logic [CNT_W-1:0] frames_done,
    output logic [CYC_W-1:0] last_latency,
    output logic             lat_valid,
    output logic             done_pulse,
    output logic             err_timeout
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_WAIT_DONE = 3'd2;
    localparam logic [2:0] ST_DRAIN     = 3'd3;
    localparam logic [2:0] ST_ERROR     = 3'd4;

    localparam logic [CYC_W-1:0] TIMEOUT_LIM = CYC_W'(TIMEOUT_CYCLES);

    logic [2:0]       state_q, state_d;
    logic             start_q, start_d;
    logic [CNT_W-1:0] framesDone_q, framesDone_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [CYC_W-1:0] lastLat_q, lastLat_d;
    logic             latValid_q, latValid_d;
    logic             donePulse_q, donePulse_d;
    logic             errTimeout_q, errTimeout_d;
    logic [CYC_W-1:0] cycInc;

    assign cmd_ready    = ap_rst_n && (state_q == ST_IDLE);
    assign acc_ap_start = start_q;
    assign busy         = (state_q != ST_IDLE);
    assign frames_done  = framesDone_q;
    assign last_latency = lastLat_q;
    assign lat_valid    = latValid_q;
    assign done_pulse   = donePulse_q;
    assign err_timeout  = errTimeout_q;

    assign cycInc = (cyc_q == '1) ? cyc_q : cyc_q + CYC_W'(1);

    always_comb begin
        state_d      = state_q;
        start_d      = start_q;
        framesDone_d = framesDone_q;
        remaining_d  = remaining_q;
        cyc_d        = cyc_q;
        lastLat_d    = lastLat_q;
        latValid_d   = 1'b0;
        donePulse_d  = 1'b0;
        errTimeout_d = errTimeout_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    framesDone_d = '0;
                    errTimeout_d = 1'b0;
                    if (cmd_frames == '0) begin
                        donePulse_d = 1'b1;
                    end else begin
                        remaining_d = cmd_frames;
                        cyc_d       = CYC_W'(1);
                        start_d     = 1'b1;
                        state_d     = ST_START;
                    end
                end
            end

            ST_START, ST_WAIT_DONE: begin
                cyc_d = cycInc;
                // A completion seen together with abort or the timeout limit is still recorded.
                if (acc_ap_done) begin
                    lastLat_d    = cyc_q;
                    latValid_d   = 1'b1;
                    framesDone_d = framesDone_q + CNT_W'(1);
                    remaining_d  = remaining_q - CNT_W'(1);
                    if (abort) begin
                        start_d = 1'b0;
                        state_d = ST_DRAIN;
                    end else if (remaining_q == CNT_W'(1)) begin
                        start_d     = 1'b0;
                        donePulse_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        cyc_d   = CYC_W'(1);
                        start_d = 1'b1;
                        state_d = ST_START;
                    end
                end else if (abort) begin
                    start_d = 1'b0;
                    state_d = ST_DRAIN;
                end else if (cyc_q == TIMEOUT_LIM) begin
                    start_d      = 1'b0;
                    errTimeout_d = 1'b1;
                    state_d      = ST_ERROR;
                end else if ((state_q == ST_START) && acc_ap_ready) begin
                    start_d = 1'b0;
                    state_d = ST_WAIT_DONE;
                end
            end

            ST_ERROR: begin
                start_d = 1'b0;
                if (abort) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                start_d = 1'b0;
                if (acc_ap_idle) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                start_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q      <= ST_IDLE;
            start_q      <= 1'b0;
            framesDone_q <= '0;
            remaining_q  <= '0;
            cyc_q        <= '0;
            lastLat_q    <= '0;
            latValid_q   <= 1'b0;
            donePulse_q  <= 1'b0;
            errTimeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            framesDone_q <= framesDone_d;
            remaining_q  <= remaining_d;
            cyc_q        <= cyc_d;
            lastLat_q    <= lastLat_d;
            latValid_q   <= latValid_d;
            donePulse_q  <= donePulse_d;
            errTimeout_q <= errTimeout_d;
        end
    end

endmodule

// File: tb/tb_hls_ctrl_sequencer.sv
// Directed bench for hls_ctrl_sequencer: the accelerator side is driven by hand,
// cycle by cycle, and every output is compared against hand-computed values.
module tb_hls_ctrl_sequencer;

    localparam int CNT_W = 16;
    localparam int CYC_W = 32;
    localparam int TMO   = 20;

    logic             ap_clk       = 1'b0;
    logic             ap_rst_n     = 1'b0;
    logic             cmd_valid    = 1'b0;
    logic [CNT_W-1:0] cmd_frames   = '0;
    logic             abort        = 1'b0;
    logic             acc_ap_ready = 1'b0;
    logic             acc_ap_done  = 1'b0;
    logic             acc_ap_idle  = 1'b1;
    logic             cmd_ready;
    logic             acc_ap_start;
    logic             busy;
    logic [CNT_W-1:0] frames_done;
    logic [CYC_W-1:0] last_latency;
    logic             lat_valid;
    logic             done_pulse;
    logic             err_timeout;

    int nChecks = 0;
    int nFail   = 0;

    hls_ctrl_sequencer #(
        .CNT_W(CNT_W),
        .CYC_W(CYC_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_frames(cmd_frames),
        .abort(abort),
        .acc_ap_start(acc_ap_start),
        .acc_ap_ready(acc_ap_ready),
        .acc_ap_done(acc_ap_done),
        .acc_ap_idle(acc_ap_idle),
        .busy(busy),
        .frames_done(frames_done),
        .last_latency(last_latency),
        .lat_valid(lat_valid),
        .done_pulse(done_pulse),
        .err_timeout(err_timeout)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Hard stop in case the sequence itself stalls.
    initial begin
        #100000;
        $display("[TB] FAIL global_timeout observed=stalled expected=finished");
        $fatal(1, "[TB] bench did not finish");
    end

    initial begin
        // Reset held three edges with a command pending: nothing may be accepted.
        ap_rst_n   = 1'b0;
        cmd_valid  = 1'b1;
        cmd_frames = 16'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rst_start", 32'(acc_ap_start), 32'd0);
            checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
            checkOutput("rst_busy", 32'(busy), 32'd0);
        end
        ap_rst_n = 1'b1;
        #1;
        checkOutput("rel_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b0;
        tick();
        checkOutput("rel_busy", 32'(busy), 32'd0);
        checkOutput("rel_start", 32'(acc_ap_start), 32'd0);

        // One frame, ready and done together on the 6th start-high cycle.
        cmd_valid  = 1'b1;
        cmd_frames = 16'd1;
        tick();
        cmd_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            checkOutput("t2_start_high", 32'(acc_ap_start), 32'd1);
            checkOutput("t2_no_latv", 32'(lat_valid), 32'd0);
            acc_ap_ready = (c == 6);
            acc_ap_done  = (c == 6);
            tick();
        end
        acc_ap_ready = 1'b0;
        acc_ap_done  = 1'b0;
        checkOutput("t2_start_low", 32'(acc_ap_start), 32'd0);
        checkOutput("t2_latency", last_latency, 32'd6);
        checkOutput("t2_latv", 32'(lat_valid), 32'd1);
        checkOutput("t2_frames", 32'(frames_done), 32'd1);
        checkOutput("t2_done_pulse", 32'(done_pulse), 32'd1);
        checkOutput("t2_busy", 32'(busy), 32'd0);
        tick();
        checkOutput("t2_latv_clr", 32'(lat_valid), 32'd0);
        checkOutput("t2_done_clr", 32'(done_pulse), 32'd0);

        // Three back-to-back frames: ready at cycle 2, done at cycle 10 of each run.
        cmd_valid  = 1'b1;
        cmd_frames = 16'd3;
        tick();
        cmd_valid = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 1; c <= 10; c++) begin
                checkOutput("t3_start", 32'(acc_ap_start), (c <= 2) ? 32'd1 : 32'd0);
                checkOutput("t3_latv", 32'(lat_valid), (r > 0 && c == 1) ? 32'd1 : 32'd0);
                checkOutput("t3_done_pulse", 32'(done_pulse), 32'd0);
                if (c == 1) begin
                    checkOutput("t3_frames_run", 32'(frames_done), 32'(r));
                    if (r > 0) checkOutput("t3_latency_run", last_latency, 32'd10);
                end
                acc_ap_ready = (c == 2);
                acc_ap_done  = (c == 10);
                tick();
            end
        end
        acc_ap_ready = 1'b0;
        acc_ap_done  = 1'b0;
        checkOutput("t3_latency", last_latency, 32'd10);
        checkOutput("t3_latv_last", 32'(lat_valid), 32'd1);
        checkOutput("t3_frames", 32'(frames_done), 32'd3);
        checkOutput("t3_done_pulse_end", 32'(done_pulse), 32'd1);
        checkOutput("t3_busy", 32'(busy), 32'd0);
        tick();
        checkOutput("t3_done_clr", 32'(done_pulse), 32'd0);

        // Zero-frame command finishes immediately and clears the previous count.
        cmd_valid  = 1'b1;
        cmd_frames = 16'd0;
        tick();
        cmd_valid = 1'b0;
        checkOutput("t6_zero_done", 32'(done_pulse), 32'd1);
        checkOutput("t6_zero_frames", 32'(frames_done), 32'd0);
        checkOutput("t6_zero_start", 32'(acc_ap_start), 32'd0);
        checkOutput("t6_zero_busy", 32'(busy), 32'd0);
        tick();
        checkOutput("t6_zero_done_clr", 32'(done_pulse), 32'd0);
        checkOutput("t6_zero_start2", 32'(acc_ap_start), 32'd0);

        // Hung run: done never comes, error after cyc reaches the limit.
        cmd_valid  = 1'b1;
        cmd_frames = 16'd1;
        tick();
        cmd_valid = 1'b0;
        for (int c = 1; c <= TMO; c++) begin
            acc_ap_ready = (c == 2);
            if (c == TMO) begin
                checkOutput("t4_pre_err", 32'(err_timeout), 32'd0);
                checkOutput("t4_pre_busy", 32'(busy), 32'd1);
            end
            tick();
        end
        acc_ap_ready = 1'b0;
        checkOutput("t4_err", 32'(err_timeout), 32'd1);
        checkOutput("t4_start", 32'(acc_ap_start), 32'd0);
        checkOutput("t4_cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("t4_no_done_pulse", 32'(done_pulse), 32'd0);
        acc_ap_ready = 1'b1;
        acc_ap_done  = 1'b1;
        tick();
        acc_ap_ready = 1'b0;
        acc_ap_done  = 1'b0;
        checkOutput("t4_err_ignore_latv", 32'(lat_valid), 32'd0);
        checkOutput("t4_err_ignore_frames", 32'(frames_done), 32'd0);
        checkOutput("t4_err_hold", 32'(err_timeout), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("t4_drain_busy", 32'(busy), 32'd1);
        tick();
        checkOutput("t4_idle_busy", 32'(busy), 32'd0);
        checkOutput("t4_err_sticky", 32'(err_timeout), 32'd1);
        cmd_valid  = 1'b1;
        cmd_frames = 16'd1;
        tick();
        cmd_valid = 1'b0;
        checkOutput("t4_err_cleared", 32'(err_timeout), 32'd0);
        checkOutput("t4_restart", 32'(acc_ap_start), 32'd1);
        acc_ap_ready = 1'b1;
        acc_ap_done  = 1'b1;
        tick();
        acc_ap_ready = 1'b0;
        acc_ap_done  = 1'b0;
        checkOutput("t4_min_latency", last_latency, 32'd1);
        checkOutput("t4_min_frames", 32'(frames_done), 32'd1);
        checkOutput("t4_min_done", 32'(done_pulse), 32'd1);
        tick();

        // Abort in WAIT_DONE; idle rises four cycles later, done in DRAIN is ignored.
        acc_ap_idle = 1'b0;
        cmd_valid   = 1'b1;
        cmd_frames  = 16'd2;
        tick();
        cmd_valid    = 1'b0;
        acc_ap_ready = 1'b1;
        tick();
        acc_ap_ready = 1'b0;
        checkOutput("t5_wait_start", 32'(acc_ap_start), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput("t5_drain_busy", 32'(busy), 32'd1);
            checkOutput("t5_drain_start", 32'(acc_ap_start), 32'd0);
            checkOutput("t5_drain_latv", 32'(lat_valid), 32'd0);
            checkOutput("t5_drain_done", 32'(done_pulse), 32'd0);
            acc_ap_done = (k == 1);
            acc_ap_idle = (k == 3);
            tick();
        end
        acc_ap_done = 1'b0;
        checkOutput("t5_idle_busy", 32'(busy), 32'd0);
        checkOutput("t5_frames", 32'(frames_done), 32'd0);
        checkOutput("t5_no_latv", 32'(lat_valid), 32'd0);
        checkOutput("t5_no_done", 32'(done_pulse), 32'd0);

        // Done lands exactly on the timeout limit: completion wins.
        cmd_valid  = 1'b1;
        cmd_frames = 16'd1;
        tick();
        cmd_valid = 1'b0;
        for (int c = 1; c <= TMO; c++) begin
            acc_ap_ready = (c == 1);
            acc_ap_done  = (c == TMO);
            tick();
        end
        acc_ap_ready = 1'b0;
        acc_ap_done  = 1'b0;
        checkOutput("t6_lim_err", 32'(err_timeout), 32'd0);
        checkOutput("t6_lim_latency", last_latency, 32'd20);
        checkOutput("t6_lim_latv", 32'(lat_valid), 32'd1);
        checkOutput("t6_lim_done", 32'(done_pulse), 32'd1);
        checkOutput("t6_lim_busy", 32'(busy), 32'd0);
        tick();

        // Abort and done in the same cycle: completion recorded, then DRAIN.
        acc_ap_idle = 1'b0;
        cmd_valid   = 1'b1;
        cmd_frames  = 16'd2;
        tick();
        cmd_valid    = 1'b0;
        acc_ap_ready = 1'b1;
        acc_ap_done  = 1'b1;
        abort        = 1'b1;
        tick();
        acc_ap_ready = 1'b0;
        acc_ap_done  = 1'b0;
        abort        = 1'b0;
        checkOutput("ab_latv", 32'(lat_valid), 32'd1);
        checkOutput("ab_latency", last_latency, 32'd1);
        checkOutput("ab_frames", 32'(frames_done), 32'd1);
        checkOutput("ab_busy", 32'(busy), 32'd1);
        checkOutput("ab_start", 32'(acc_ap_start), 32'd0);
        checkOutput("ab_no_done", 32'(done_pulse), 32'd0);
        acc_ap_idle = 1'b1;
        tick();
        checkOutput("ab_idle", 32'(busy), 32'd0);
        checkOutput("ab_frames_hold", 32'(frames_done), 32'd1);

        // Reset in the middle of a run drops ap_start and clears the counters.
        cmd_valid  = 1'b1;
        cmd_frames = 16'd1;
        tick();
        cmd_valid = 1'b0;
        checkOutput("mr_start", 32'(acc_ap_start), 32'd1);
        ap_rst_n = 1'b0;
        tick();
        checkOutput("mr_start_low", 32'(acc_ap_start), 32'd0);
        checkOutput("mr_busy", 32'(busy), 32'd0);
        checkOutput("mr_frames", 32'(frames_done), 32'd0);
        checkOutput("mr_latency", last_latency, 32'd0);
        checkOutput("mr_cmd_ready", 32'(cmd_ready), 32'd0);
        ap_rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
